// File: rtl/anti_pinch_mc.sv
// Multi-channel anti-pinch motor controller: shared tick timebase, two-flop input
// synchronisers, per-key debounce and a per-channel IDLE/UP/DOWN/REVERSE state machine.
module anti_pinch_mc #(
    parameter int N_CH      = 2,
    parameter int TICK_DIV  = 100000,
    parameter int DEB_TICKS = 20,
    parameter int REV_TICKS = 500,
    parameter int MAX_TICKS = 8000,
    parameter int CNT_W     = 16
) (
    input  logic                SYSCLK,
    input  logic                RST,
    input  logic [N_CH-1:0]     key_up,
    input  logic [N_CH-1:0]     key_down,
    input  logic [N_CH-1:0]     stop_signal,
    output logic [2*N_CH-1:0]   MOTOR,
    output logic [N_CH-1:0]     pinch_evt,
    output logic [N_CH-1:0]     busy
);

    localparam int TB_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, UP, DOWN, REVERSE} state_t;

    logic [TB_W-1:0]     tb_cnt;
    logic                tick;
    logic [3*N_CH-1:0]   raw;
    logic [3*N_CH-1:0]   sync_a;
    logic [3*N_CH-1:0]   sync_b;
    logic [2*N_CH-1:0]   deb_level;
    logic [2*N_CH-1:0]   deb_prev;
    logic [2*N_CH-1:0]   press;
    logic [N_CH-1:0]     press_up;
    logic [N_CH-1:0]     press_dn;
    logic [N_CH-1:0]     stop_s;

    assign tick = (tb_cnt == TB_W'(TICK_DIV - 1));

    always_ff @(posedge SYSCLK) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            tb_cnt <= '0;
        end else if (tick) begin
            tb_cnt <= '0;
        end else begin
            tb_cnt <= tb_cnt + 1'b1;
        end
    end

    // Keys and pinch sensor are asynchronous; bit layout is {stop, down, up}.
    assign raw = {stop_signal, key_down, key_up};

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    for (genvar k = 0; k < 2*N_CH; k++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge SYSCLK) begin
            if (RST) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync_b[k] == lvl) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CNT_W'(DEB_TICKS - 1)) begin
                    lvl <= sync_b[k];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb_level[k] = lvl;
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            deb_prev <= '0;
        end else begin
            deb_prev <= deb_level;
        end
    end

    // Press is the single cycle in which the debounced level is newly high.
    assign press    = deb_level & ~deb_prev;
    assign press_up = press[N_CH-1:0];
    assign press_dn = press[2*N_CH-1:N_CH];
    assign stop_s   = sync_b[3*N_CH-1:2*N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] travel;
        logic             pinch_nxt;
        logic [1:0]       motor_nxt;
        logic [1:0]       motor_r;
        logic             pinch_r;
        logic             busy_r;
        logic             any_press;
        logic             move_done;
        logic             rev_done;

        assign any_press = press_up[c] | press_dn[c];
        assign move_done = tick && (travel == CNT_W'(MAX_TICKS - 1));
        assign rev_done  = tick && (travel == CNT_W'(REV_TICKS - 1));

        always_comb begin
            // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
            state_nxt = state;
            pinch_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (press_up[c] && !press_dn[c]) begin
                        state_nxt = UP;
                    end else if (press_dn[c] && !press_up[c]) begin
                        state_nxt = DOWN;
                    end
                end
                UP: begin
                    if (stop_s[c]) begin
                        state_nxt = REVERSE;
                        pinch_nxt = 1'b1;
                    end else if (move_done || any_press) begin
                        state_nxt = IDLE;
                    end
                end
                DOWN: begin
                    if (move_done || any_press) begin
                        state_nxt = IDLE;
                    end
                end
                REVERSE: begin
                    if (rev_done) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            motor_nxt = 2'b00;
            case (state_nxt)
                UP:            motor_nxt = 2'b01;
                DOWN, REVERSE: motor_nxt = 2'b10;
                default:       motor_nxt = 2'b00;
            endcase
        end

        always_ff @(posedge SYSCLK) begin
            // NOTE: every flop here is reset so a mid-motion reset stops the motor on the sampling edge.
            if (RST) begin
                state   <= IDLE;
                travel  <= '0;
                motor_r <= 2'b00;
                pinch_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                state   <= state_nxt;
                pinch_r <= pinch_nxt;
                busy_r  <= (state_nxt != IDLE);
                motor_r <= motor_nxt;
                if (state_nxt != state) begin
                    travel <= '0;
                end else if (tick && (travel != '1)) begin
                    travel <= travel + 1'b1;
                end
            end
        end

        assign MOTOR[2*c+1:2*c] = motor_r;
        assign pinch_evt[c]     = pinch_r;
        assign busy[c]          = busy_r;
    end

endmodule

// File: tb/tb_anti_pinch_mc.sv
// Bench for anti_pinch_mc: a per-cycle behavioural model feeds a scoreboard queue,
// plus directed scenarios measuring latency and duration windows.
module tb_anti_pinch_mc;

    localparam int N_CH = 2;
    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int REV  = 5;
    localparam int MAXT = 20;

    logic                SYSCLK = 1'b0;
    logic                RST = 1'b1;
    logic [N_CH-1:0]     key_up = '0;
    logic [N_CH-1:0]     key_down = '0;
    logic [N_CH-1:0]     stop_signal = '0;
    logic [2*N_CH-1:0]   MOTOR;
    logic [N_CH-1:0]     pinch_evt;
    logic [N_CH-1:0]     busy;

    always #5 SYSCLK = ~SYSCLK;

    anti_pinch_mc #(
        .N_CH(N_CH), .TICK_DIV(TD), .DEB_TICKS(DEB),
        .REV_TICKS(REV), .MAX_TICKS(MAXT), .CNT_W(16)
    ) dut (
        .SYSCLK(SYSCLK), .RST(RST),
        .key_up(key_up), .key_down(key_down), .stop_signal(stop_signal),
        .MOTOR(MOTOR), .pinch_evt(pinch_evt), .busy(busy)
    );

    typedef struct packed {
        logic [2*N_CH-1:0] motor;
        logic [N_CH-1:0]   pinch;
        logic [N_CH-1:0]   busy;
    } exp_t;

    typedef enum {M_IDLE, M_UP, M_DOWN, M_REV} mst_e;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val >= lo && val <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
    endtask

    // Reference model: countdown of remaining ticks per motion, delay-line synchronisers,
    // debounce as "ticks of disagreement", evaluated once per rising edge.
    initial begin : model
        mst_e              st   [N_CH];
        int                left [N_CH];
        bit                s1   [3*N_CH];
        bit                s2   [3*N_CH];
        bit                deb  [2*N_CH];
        bit                rose [2*N_CH];
        int                run  [2*N_CH];
        int                phase;
        bit                tick;
        bit                pu, pd, stp;
        logic [3*N_CH-1:0] raw;
        exp_t              e;
        phase = 0;
        forever begin
            @(posedge SYSCLK);
            raw = {stop_signal, key_down, key_up};
            e = '0;
            if (RST) begin
                for (int c = 0; c < N_CH; c++) begin
                    st[c] = M_IDLE;
                    left[c] = 0;
                end
                for (int k = 0; k < 3*N_CH; k++) begin
                    s1[k] = 1'b0;
                    s2[k] = 1'b0;
                end
                for (int k = 0; k < 2*N_CH; k++) begin
                    deb[k] = 1'b0;
                    rose[k] = 1'b0;
                    run[k] = 0;
                end
                phase = 0;
            end else begin
                tick = (phase == TD - 1);
                for (int c = 0; c < N_CH; c++) begin
                    pu  = rose[c];
                    pd  = rose[N_CH + c];
                    stp = s2[2*N_CH + c];
                    case (st[c])
                        M_IDLE: begin
                            if (pu && !pd) begin st[c] = M_UP; left[c] = MAXT; end
                            else if (pd && !pu) begin st[c] = M_DOWN; left[c] = MAXT; end
                        end
                        M_UP: begin
                            if (stp) begin
                                st[c] = M_REV; left[c] = REV; e.pinch[c] = 1'b1;
                            end else if (tick && left[c] == 1) st[c] = M_IDLE;
                            else if (pu || pd) st[c] = M_IDLE;
                            else if (tick) left[c]--;
                        end
                        M_DOWN: begin
                            if (tick && left[c] == 1) st[c] = M_IDLE;
                            else if (pu || pd) st[c] = M_IDLE;
                            else if (tick) left[c]--;
                        end
                        default: begin
                            if (tick && left[c] == 1) st[c] = M_IDLE;
                            else if (tick) left[c]--;
                        end
                    endcase
                end
                for (int k = 0; k < 2*N_CH; k++) begin
                    rose[k] = 1'b0;
                    if (s2[k] == deb[k]) run[k] = 0;
                    else if (tick) begin
                        run[k]++;
                        if (run[k] == DEB) begin
                            deb[k] = s2[k];
                            run[k] = 0;
                            rose[k] = deb[k];
                        end
                    end
                end
                for (int k = 0; k < 3*N_CH; k++) begin
                    s2[k] = s1[k];
                    s1[k] = raw[k];
                end
                phase = (phase + 1) % TD;
            end
            for (int c = 0; c < N_CH; c++) begin
                e.motor[2*c +: 2] = (st[c] == M_UP) ? 2'b01 :
                                    (st[c] == M_IDLE) ? 2'b00 : 2'b10;
                e.busy[c] = (st[c] != M_IDLE);
            end
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge SYSCLK);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("cycle_outputs", 32'({MOTOR, pinch_evt, busy}), 32'(e));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge SYSCLK);
    endtask

    task automatic wait_motor(input int c, input logic [1:0] v, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge SYSCLK);
            if (MOTOR[2*c +: 2] == v) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin : stim
        int n, m;
        bit moved, bad0, bad1;

        // Reset
        cycles(3);
        RST = 1'b0;
        check("reset_motor", 32'(MOTOR), 32'(0));
        check("reset_pinch", 32'(pinch_evt), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        moved = 1'b0;
        repeat (200) begin
            @(negedge SYSCLK);
            if (MOTOR != '0 || busy != '0) moved = 1'b1;
        end
        check("idle_after_reset", 32'(moved), 32'(0));

        // Bounce on ch0 up key, then settle high
        bad0 = 1'b0;
        bad1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_up[0] = (i % 2 == 0);
            repeat (2) begin
                @(negedge SYSCLK);
                if (MOTOR[1:0] != 2'b00) bad0 = 1'b1;
                if (MOTOR[3:2] != 2'b00) bad1 = 1'b1;
            end
        end
        check("bounce_no_motion", 32'(bad0), 32'(0));
        key_up[0] = 1'b1;
        wait_motor(0, 2'b01, 40, n);
        check_range("bounce_settle_latency", n, 12, 20);
        check("bounce_ch1_quiet", 32'({bad1, MOTOR[3:2]}), 32'(0));

        // Pinch while in UP, then keys ignored during REVERSE
        key_up[0] = 1'b0;
        cycles(3);
        stop_signal[0] = 1'b1;
        cycles(2);
        check("pre_pinch_motor", 32'(MOTOR[1:0]), 32'(2'b01));
        check("pre_pinch_evt", 32'(pinch_evt[0]), 32'(0));
        @(negedge SYSCLK);
        check("pinch_motor", 32'(MOTOR[1:0]), 32'(2'b10));
        check("pinch_evt", 32'(pinch_evt[0]), 32'(1));
        key_down[0] = 1'b1;
        @(negedge SYSCLK);
        check("pinch_one_cycle", 32'(pinch_evt[0]), 32'(0));
        wait_motor(0, 2'b00, 30, m);
        check_range("reverse_len", (m < 0) ? -1 : m + 1, 16, 20);
        check("reverse_busy_fall", 32'(busy[0]), 32'(0));
        key_down[0] = 1'b0;
        stop_signal[0] = 1'b0;
        cycles(20);

        // Timeout on ch1 in DOWN
        key_down[1] = 1'b1;
        wait_motor(1, 2'b10, 40, n);
        check_range("down_latency_ch1", n, 12, 20);
        check("down_busy_ch1", 32'(busy[1]), 32'(1));
        key_down[1] = 1'b0;
        wait_motor(1, 2'b00, 100, m);
        check_range("timeout_len_ch1", m, 76, 80);
        check("timeout_busy_fall", 32'(busy[1]), 32'(0));
        check("timeout_ch0_quiet", 32'(MOTOR[1:0]), 32'(0));
        cycles(5);

        // Toggle-stop: down press while in UP
        key_up[0] = 1'b1;
        wait_motor(0, 2'b01, 40, n);
        check_range("up_latency", n, 12, 20);
        key_up[0] = 1'b0;
        cycles(16);
        key_down[0] = 1'b1;
        wait_motor(0, 2'b00, 40, n);
        check_range("toggle_stop_latency", n, 12, 20);
        key_down[0] = 1'b0;
        cycles(20);

        // Simultaneous press from IDLE
        key_up[0] = 1'b1;
        key_down[0] = 1'b1;
        moved = 1'b0;
        repeat (30) begin
            @(negedge SYSCLK);
            if (MOTOR[1:0] != 2'b00) moved = 1'b1;
        end
        check("simul_press_idle", 32'(moved), 32'(0));
        key_up[0] = 1'b0;
        key_down[0] = 1'b0;
        cycles(20);

        // stop_signal ignored while in DOWN
        key_down[0] = 1'b1;
        wait_motor(0, 2'b10, 40, n);
        check_range("down_latency_ch0", n, 12, 20);
        key_down[0] = 1'b0;
        stop_signal[0] = 1'b1;
        moved = 1'b0;
        repeat (12) begin
            @(negedge SYSCLK);
            if (pinch_evt[0] || MOTOR[1:0] != 2'b10) moved = 1'b1;
        end
        check("stop_ignored_in_down", 32'(moved), 32'(0));
        stop_signal[0] = 1'b0;
        wait_motor(0, 2'b00, 100, m);
        check_range("down_timeout_ch0", m + 13, 76, 80);
        cycles(5);

        // Reset during REVERSE
        key_up[0] = 1'b1;
        wait_motor(0, 2'b01, 40, n);
        key_up[0] = 1'b0;
        cycles(3);
        stop_signal[0] = 1'b1;
        wait_motor(0, 2'b10, 10, n);
        check_range("pinch2_latency", n, 3, 3);
        cycles(4);
        RST = 1'b1;
        @(negedge SYSCLK);
        check("midrev_reset_motor", 32'(MOTOR), 32'(0));
        check("midrev_reset_busy", 32'(busy), 32'(0));
        RST = 1'b0;
        moved = 1'b0;
        repeat (40) begin
            @(negedge SYSCLK);
            if (MOTOR != '0 || busy != '0) moved = 1'b1;
            stop_signal[0] = 1'b0;
        end
        check("no_resume_after_reset", 32'(moved), 32'(0));

        // Randomised activity against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge SYSCLK);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 39) == 0) key_up[c] = ~key_up[c];
                if ($urandom_range(0, 39) == 0) key_down[c] = ~key_down[c];
                if ($urandom_range(0, 59) == 0) stop_signal[c] = ~stop_signal[c];
            end
            RST = ($urandom_range(0, 1999) == 0);
        end
        RST = 1'b0;
        key_up = '0;
        key_down = '0;
        stop_signal = '0;
        cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/anti_pinch_mc.md
# anti_pinch_mc

Multi-channel anti-pinch window/door motor controller with integrated tick generation, key debouncing, pinch auto-reverse and travel timeout. Each of N_CH channels takes raw up/down keys and a pressure-sensor stop input and drives a 2-bit motor command. It sits directly below the board top level, runs from the 100 MHz system clock, and replaces the separate clock-divider, debounce and single-channel controller chain.

## Interface
- N_CH, 2: number of independent motor channels.
- TICK_DIV, 100000: SYSCLK cycles per timebase tick (1 ms at 100 MHz).
- DEB_TICKS, 20: ticks a raw key level must stay stable before the debounced level follows it.
- REV_TICKS, 500: auto-reverse duration in ticks after a pinch.
- MAX_TICKS, 8000: travel timeout in ticks for UP/DOWN motion.
- CNT_W, 16: width of per-channel tick counters; must hold max(DEB_TICKS, REV_TICKS, MAX_TICKS).
- SYSCLK  in  1  system clock; the only clock.
- RST  in  1  reset; synchronous and active-high.
- key_up  in  N_CH  raw close key per channel, active-high, asynchronous.
- key_down  in  N_CH  raw open key per channel, active-high, asynchronous.
- stop_signal  in  N_CH  pressure-sensor pinch input per channel, active-high, asynchronous.
- MOTOR  out  2*N_CH  per channel c, MOTOR[2c+1:2c]: 2'b01 close (up), 2'b10 open (down), 2'b00 stop; 2'b11 never driven.
- pinch_evt  out  N_CH  one-cycle pulse when a pinch is detected on that channel.
- busy  out  N_CH  high while the channel is in UP, DOWN or REVERSE.

## Operation
- Timebase: a shared counter runs 0..TICK_DIV-1 and wraps. The internal tick strobe is high for one cycle when the count equals TICK_DIV-1.
- Synchronisers: every key_up, key_down and stop_signal bit passes through two flops before use.
- Debounce, per key:
  - The counter clears whenever the synced level equals the debounced level.
  - On each tick where the two differ, the counter increments. On the DEB_TICKS-th such tick, the debounced level takes the synced value and the counter clears.
  - A press pulse is high for exactly the cycle in which the debounced level is newly 1. Release generates no event.
- stop_signal is synchronised only, not debounced, to minimise pinch latency.
- Per-channel FSM: states IDLE, UP, DOWN, REVERSE. The travel counter clears on every state entry and increments on each tick, saturating at its maximum.
  - IDLE (MOTOR 00):
    - up press alone → UP.
    - down press alone → DOWN.
    - Both presses in the same cycle → stay in IDLE.
  - UP (MOTOR 01). Priority order:
    - synced stop_signal high → REVERSE, and pinch_evt pulses on the same edge.
    - travel counter reaches MAX_TICKS on a tick → IDLE.
    - any press → IDLE (toggle-stop).
  - DOWN (MOTOR 10):
    - travel counter reaches MAX_TICKS → IDLE.
    - any press → IDLE.
    - stop_signal is ignored in this state.
  - REVERSE (MOTOR 10):
    - keys and stop_signal are ignored.
    - travel counter reaches REV_TICKS → IDLE, even if stop_signal is still high.
- Channels are fully independent; activity on one channel never affects another.
- MOTOR, busy and pinch_evt are registered and update on the same edge as the state register.

## Timing
- Reset: while RST is sampled high, and on the first edge afterwards, the following are 0: MOTOR, pinch_evt, busy, all counters, debounced levels and sync flops. All FSMs are in IDLE. Reset mid-motion stops the motor on the sampling edge with no resume afterwards.
- Pinch latency: stop_signal stable high before edge 0 gives a synced level after edge 1. MOTOR goes 01→10 and pinch_evt pulses at edge 2.
- Key latency: the press is acted on at the edge ending the press-pulse cycle, i.e. after 2 sync edges plus DEB_TICKS ticks of stability. That is DEB_TICKS·TICK_DIV + 3 cycles, ± TICK_DIV for tick phase.
- Timeout granularity is one tick: motion lasts between (MAX_TICKS-1)·TICK_DIV and MAX_TICKS·TICK_DIV cycles. REVERSE duration follows the same rule with REV_TICKS.
- A pinch and a timeout in the same cycle resolve to REVERSE.

## Test plan
Parameters for all scenarios: N_CH=2, TICK_DIV=4, DEB_TICKS=3, REV_TICKS=5, MAX_TICKS=20.
- Reset: RST high 3 cycles with all inputs low → MOTOR=4'b0000, pinch_evt=0, busy=0. No motion for 200 cycles afterwards.
- Bounce: key_up[0] toggles every 2 cycles for 40 cycles, then is held high:
  - MOTOR[1:0] stays 00 during the toggling.
  - MOTOR[1:0] becomes 01 12-20 cycles after the key settles.
  - MOTOR[3:2] stays 00 throughout.
- Pinch: ch0 in UP, stop_signal[0] raised:
  - pinch_evt[0] pulses 1 cycle, and MOTOR[1:0]=10 exactly 2 edges after stop_signal is first sampled high.
  - MOTOR[1:0] holds 10 for 16-20 cycles while key presses are ignored, then returns to 00 with busy[0]=0.
- Timeout: ch1 started in DOWN, no further input → MOTOR[3:2]=10 for 76-80 cycles, then 00, with busy[1] falling on the same edge.
- Toggle-stop / simultaneous press:
  - down press while in UP → MOTOR 00.
  - both keys pressed in the same cycle from IDLE → stays 00.
  - stop_signal while in DOWN → no pinch_evt, motion continues.
- Reset mid-REVERSE: RST pulsed for 1 cycle → MOTOR and busy are 0 on the sampling edge, and the channel stays in IDLE afterwards.
